// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory-wait freeze, redirect dump/flush, load-use bubble.
// Optional operand forwarding is enabled by defining HAZARD_FORWARDING_EN.
module hazard_control_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  valid_Decode,
  input  logic [REG_ADDR_W-1:0] rs1_Decode,
  input  logic [REG_ADDR_W-1:0] rs2_Decode,
  input  logic                  rs1_used_Decode,
  input  logic                  rs2_used_Decode,
  input  logic [REG_ADDR_W-1:0] writeback_Reg_Execute,
  input  logic                  reg_wEn_Execute,
  input  logic                  mem_read_Execute,
  input  logic [REG_ADDR_W-1:0] writeback_Reg_Memory,
  input  logic                  reg_wEn_Memory,
  input  logic                  mem_read_Memory,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] writeback_Reg_Writeback,
  input  logic                  reg_wEn_Writeback,
  input  logic                  next_PC_select_Execute,
  output logic                  STALL_PC,
  output logic                  STALL_Fetch_Decode,
  output logic                  STALL_Decode_Execute,
  output logic                  STALL_Execute_Memory,
  output logic                  DUMP_Fetch_Decode,
  output logic                  DUMP_Decode_Execute,
  output logic [1:0]            forward_A_sel,
  output logic [1:0]            forward_B_sel
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  logic [0:0] state_reg, state_next;
  logic [2:0] flush_cnt_reg, flush_cnt_next;

  logic [REG_ADDR_W-1:0] rs [2];
  logic [1:0] rs_used;
  logic [1:0] match_ex, match_mem, match_wb;
  logic [1:0] fwd_sel [2];
  logic       load_use;
  logic       mem_wait;

  assign rs[0]   = rs1_Decode;
  assign rs[1]   = rs2_Decode;
  assign rs_used = {rs2_used_Decode, rs1_used_Decode};

  // A destination only matches when it is actually written and is not x0.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign match_ex[gi]  = reg_wEn_Execute && (writeback_Reg_Execute != '0) &&
                             (rs[gi] == writeback_Reg_Execute);
      assign match_mem[gi] = reg_wEn_Memory && (writeback_Reg_Memory != '0) &&
                             (rs[gi] == writeback_Reg_Memory);
      assign match_wb[gi]  = reg_wEn_Writeback && (writeback_Reg_Writeback != '0) &&
                             (rs[gi] == writeback_Reg_Writeback);
`ifdef HAZARD_FORWARDING_EN
      assign fwd_sel[gi] = match_mem[gi] ? 2'b01 :
                           match_wb[gi]  ? 2'b10 : 2'b00;
`else
      assign fwd_sel[gi] = 2'b00;
`endif
    end
  endgenerate

`ifdef HAZARD_FORWARDING_EN
  assign load_use = valid_Decode && mem_read_Execute && |(match_ex & rs_used);
`else
  // Without forwarding every in-flight producer blocks its consumer.
  assign load_use = valid_Decode && |((match_ex | match_mem | match_wb) & rs_used);
  logic unused_mem_read_execute;
  assign unused_mem_read_execute = mem_read_Execute;
`endif

  assign mem_wait = mem_read_Memory && !mem_ready;

  always_comb begin
    STALL_PC             = 1'b0;
    STALL_Fetch_Decode   = 1'b0;
    STALL_Decode_Execute = 1'b0;
    STALL_Execute_Memory = 1'b0;
    DUMP_Fetch_Decode    = 1'b0;
    DUMP_Decode_Execute  = 1'b0;
    forward_A_sel        = fwd_sel[0];
    forward_B_sel        = fwd_sel[1];
    state_next           = state_reg;
    flush_cnt_next       = flush_cnt_reg;

    if (!reset_n) begin
      DUMP_Fetch_Decode   = 1'b1;
      DUMP_Decode_Execute = 1'b1;
      forward_A_sel       = 2'b00;
      forward_B_sel       = 2'b00;
    end else if (mem_wait) begin
      STALL_PC             = 1'b1;
      STALL_Fetch_Decode   = 1'b1;
      STALL_Decode_Execute = 1'b1;
      STALL_Execute_Memory = 1'b1;
    end else if (next_PC_select_Execute) begin
      DUMP_Fetch_Decode   = 1'b1;
      DUMP_Decode_Execute = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_next     = ST_FLUSH;
        flush_cnt_next = FLUSH_INIT;
      end
    end else if (state_reg == ST_FLUSH) begin
      DUMP_Fetch_Decode = 1'b1;
      flush_cnt_next    = flush_cnt_reg - 3'd1;
      if (flush_cnt_reg <= 3'd1) state_next = ST_RUN;
    end else if (load_use) begin
      STALL_PC            = 1'b1;
      STALL_Fetch_Decode  = 1'b1;
      DUMP_Decode_Execute = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 3'd0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (FLUSH_CYCLES=2); expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_control_unit;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Bit order: STALL_PC, STALL_FD, STALL_DE, STALL_EM, DUMP_FD, DUMP_DE, fwdA[1:0], fwdB[1:0]
  localparam logic [9:0] IDLE   = 10'b0000_00_00_00;
  localparam logic [9:0] MEMW   = 10'b1111_00_00_00;
  localparam logic [9:0] REDIR  = 10'b0000_11_00_00;
  localparam logic [9:0] FLUSHD = 10'b0000_10_00_00;
  localparam logic [9:0] LU     = 10'b1100_01_00_00;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       valid_Decode;
  logic [4:0] rs1_Decode, rs2_Decode;
  logic       rs1_used_Decode, rs2_used_Decode;
  logic [4:0] writeback_Reg_Execute;
  logic       reg_wEn_Execute, mem_read_Execute;
  logic [4:0] writeback_Reg_Memory;
  logic       reg_wEn_Memory, mem_read_Memory, mem_ready;
  logic [4:0] writeback_Reg_Writeback;
  logic       reg_wEn_Writeback;
  logic       next_PC_select_Execute;
  logic       STALL_PC, STALL_Fetch_Decode, STALL_Decode_Execute, STALL_Execute_Memory;
  logic       DUMP_Fetch_Decode, DUMP_Decode_Execute;
  logic [1:0] forward_A_sel, forward_B_sel;
  logic [9:0] obs;
  logic [9:0] exp_v;
  logic [9:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hazard_control_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .valid_Decode(valid_Decode), .rs1_Decode(rs1_Decode), .rs2_Decode(rs2_Decode),
    .rs1_used_Decode(rs1_used_Decode), .rs2_used_Decode(rs2_used_Decode),
    .writeback_Reg_Execute(writeback_Reg_Execute), .reg_wEn_Execute(reg_wEn_Execute),
    .mem_read_Execute(mem_read_Execute),
    .writeback_Reg_Memory(writeback_Reg_Memory), .reg_wEn_Memory(reg_wEn_Memory),
    .mem_read_Memory(mem_read_Memory), .mem_ready(mem_ready),
    .writeback_Reg_Writeback(writeback_Reg_Writeback), .reg_wEn_Writeback(reg_wEn_Writeback),
    .next_PC_select_Execute(next_PC_select_Execute),
    .STALL_PC(STALL_PC), .STALL_Fetch_Decode(STALL_Fetch_Decode),
    .STALL_Decode_Execute(STALL_Decode_Execute), .STALL_Execute_Memory(STALL_Execute_Memory),
    .DUMP_Fetch_Decode(DUMP_Fetch_Decode), .DUMP_Decode_Execute(DUMP_Decode_Execute),
    .forward_A_sel(forward_A_sel), .forward_B_sel(forward_B_sel)
  );

  assign obs = {STALL_PC, STALL_Fetch_Decode, STALL_Decode_Execute, STALL_Execute_Memory,
                DUMP_Fetch_Decode, DUMP_Decode_Execute, forward_A_sel, forward_B_sel};

  task automatic set_idle();
    valid_Decode = 1'b0; rs1_Decode = 5'd0; rs2_Decode = 5'd0;
    rs1_used_Decode = 1'b0; rs2_used_Decode = 1'b0;
    writeback_Reg_Execute = 5'd0; reg_wEn_Execute = 1'b0; mem_read_Execute = 1'b0;
    writeback_Reg_Memory = 5'd0; reg_wEn_Memory = 1'b0; mem_read_Memory = 1'b0;
    mem_ready = 1'b1; writeback_Reg_Writeback = 5'd0; reg_wEn_Writeback = 1'b0;
    next_PC_select_Execute = 1'b0;
  endtask

  task automatic load_use_x5();
    writeback_Reg_Execute = 5'd5; reg_wEn_Execute = 1'b1; mem_read_Execute = 1'b1;
    valid_Decode = 1'b1; rs1_Decode = 5'd5; rs1_used_Decode = 1'b1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      set_idle();
      reset_n = (s == 2);
      writeback_Reg_Memory = 5'd7; reg_wEn_Memory = 1'b1;
      valid_Decode = 1'b1; rs2_Decode = 5'd7; rs2_used_Decode = 1'b1;
      if (s < 2) exp_q.push_back(REDIR);
      else       exp_q.push_back(FWD ? 10'b0000_00_00_01 : LU);
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL reset step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_use();
    for (int s = 0; s < 4; s++) begin
      set_idle();
      valid_Decode = 1'b1; rs1_Decode = 5'd5; rs1_used_Decode = 1'b1;
      case (s)
        0: begin load_use_x5(); exp_q.push_back(LU); end
        1: begin
          writeback_Reg_Memory = 5'd5; reg_wEn_Memory = 1'b1; mem_read_Memory = 1'b1;
          exp_q.push_back(FWD ? 10'b0000_00_01_00 : LU);
        end
        2: begin
          writeback_Reg_Writeback = 5'd5; reg_wEn_Writeback = 1'b1;
          exp_q.push_back(FWD ? 10'b0000_00_10_00 : LU);
        end
        default: exp_q.push_back(IDLE);
      endcase
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL load_use step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_alu_chain();
    for (int s = 0; s < 4; s++) begin
      set_idle();
      valid_Decode = 1'b1; rs2_Decode = 5'd3; rs2_used_Decode = 1'b1;
      case (s)
        0: begin
          writeback_Reg_Execute = 5'd3; reg_wEn_Execute = 1'b1;
          exp_q.push_back(FWD ? IDLE : LU);
        end
        1: begin
          writeback_Reg_Memory = 5'd3; reg_wEn_Memory = 1'b1;
          exp_q.push_back(FWD ? 10'b0000_00_00_01 : LU);
        end
        2: begin
          writeback_Reg_Writeback = 5'd3; reg_wEn_Writeback = 1'b1;
          exp_q.push_back(FWD ? 10'b0000_00_00_10 : LU);
        end
        default: exp_q.push_back(IDLE);
      endcase
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL alu_chain step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_redirect();
    for (int s = 0; s < 5; s++) begin
      set_idle();
      if (s != 4) load_use_x5();
      case (s)
        0: begin next_PC_select_Execute = 1'b1; exp_q.push_back(REDIR); end
        1, 2: exp_q.push_back(FLUSHD);
        3: exp_q.push_back(LU);
        default: exp_q.push_back(IDLE);
      endcase
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL redirect step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mem_wait();
    for (int s = 0; s < 7; s++) begin
      set_idle();
      if (s < 4) begin
        mem_read_Memory = 1'b1; next_PC_select_Execute = 1'b1;
        mem_ready = (s == 3);
      end
      if (s == 1) load_use_x5();
      case (s)
        0, 1, 2: exp_q.push_back(MEMW);
        3: exp_q.push_back(REDIR);
        4, 5: exp_q.push_back(FLUSHD);
        default: exp_q.push_back(IDLE);
      endcase
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL mem_wait step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mem_wait_in_flush();
    for (int s = 0; s < 6; s++) begin
      set_idle();
      case (s)
        0: begin next_PC_select_Execute = 1'b1; exp_q.push_back(REDIR); end
        1, 4: exp_q.push_back(FLUSHD);
        2, 3: begin mem_read_Memory = 1'b1; mem_ready = 1'b0; exp_q.push_back(MEMW); end
        default: exp_q.push_back(IDLE);
      endcase
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL flush_hold step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_x0_priority();
    for (int s = 0; s < 5; s++) begin
      set_idle();
      case (s)
        0: begin
          valid_Decode = 1'b1; rs1_used_Decode = 1'b1; rs2_used_Decode = 1'b1;
          reg_wEn_Execute = 1'b1; mem_read_Execute = 1'b1;
          reg_wEn_Memory = 1'b1; reg_wEn_Writeback = 1'b1;
          exp_q.push_back(IDLE);
        end
        1: begin
          valid_Decode = 1'b1; rs2_Decode = 5'd7; rs2_used_Decode = 1'b1;
          writeback_Reg_Memory = 5'd7; reg_wEn_Memory = 1'b1;
          writeback_Reg_Writeback = 5'd7; reg_wEn_Writeback = 1'b1;
          exp_q.push_back(FWD ? 10'b0000_00_00_01 : LU);
        end
        2: begin
          valid_Decode = 1'b1; rs2_Decode = 5'd7; rs2_used_Decode = 1'b1;
          writeback_Reg_Memory = 5'd7; reg_wEn_Memory = 1'b0;
          writeback_Reg_Writeback = 5'd7; reg_wEn_Writeback = 1'b1;
          exp_q.push_back(FWD ? 10'b0000_00_00_10 : LU);
        end
        3: begin load_use_x5(); valid_Decode = 1'b0; exp_q.push_back(IDLE); end
        default: begin load_use_x5(); rs1_used_Decode = 1'b0; exp_q.push_back(IDLE); end
      endcase
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL x0_priority step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    for (int s = 0; s < 5; s++) begin
      set_idle();
      reset_n = !(s == 2 || s == 3);
      case (s)
        0: begin next_PC_select_Execute = 1'b1; exp_q.push_back(REDIR); end
        1: exp_q.push_back(FLUSHD);
        2, 3: exp_q.push_back(REDIR);
        default: exp_q.push_back(IDLE);
      endcase
      @(negedge clock); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL reset_mid_flush step %0d: got %b expected %b", s, obs, exp_v);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_alu_chain();
    test_redirect();
    test_mem_wait();
    test_mem_wait_in_flush();
    test_x0_priority();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller that generates the STALL and DUMP signals consumed by the Fetch/Decode and Decode/Execute pipeline moderators. It resolves hazards in priority order: data-memory wait, taken branch/jump redirect, then load-use.
- Memory wait freezes the pipeline.
- A redirect dumps wrong-path instructions.
- A load-use hazard holds Decode and inserts a bubble.

With forwarding compiled in, it also drives the operand-forwarding selects for Execute. It sits beside the pipeline registers, between Decode and Memory.

## Interface
- REG_ADDR_W, 5, register-address width
- FLUSH_CYCLES, 1, extra cycles Fetch/Decode is dumped after a redirect (legal 0..7)

Ports:
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_Decode  in  1  Decode holds a real instruction
- rs1_Decode, rs2_Decode  in  REG_ADDR_W  Decode source registers
- rs1_used_Decode, rs2_used_Decode  in  1  source actually read
- writeback_Reg_Execute  in  REG_ADDR_W  Execute destination register
- reg_wEn_Execute  in  1  Execute writes a register
- mem_read_Execute  in  1  Execute instruction is a load
- writeback_Reg_Memory  in  REG_ADDR_W  Memory destination register
- reg_wEn_Memory  in  1  Memory writes a register
- mem_read_Memory  in  1  Memory instruction is a load
- mem_ready  in  1  data memory has returned the load data
- writeback_Reg_Writeback  in  REG_ADDR_W  Writeback destination register
- reg_wEn_Writeback  in  1  Writeback writes a register
- next_PC_select_Execute  in  1  branch/jump resolved taken in Execute
- STALL_PC  out  1  hold the PC
- STALL_Fetch_Decode  out  1  hold the Fetch/Decode moderator
- STALL_Decode_Execute  out  1  hold the Decode/Execute moderator
- STALL_Execute_Memory  out  1  hold the Execute/Memory moderator
- DUMP_Fetch_Decode  out  1  load a bubble into Fetch/Decode
- DUMP_Decode_Execute  out  1  load a bubble into Decode/Execute
- forward_A_sel, forward_B_sel  out  2  00 register file, 01 Memory result, 10 Writeback result

## Operation
- A source register "matches" a destination only when the destination register is nonzero and that stage's reg_wEn is 1. Register x0 never matches.
- States:
  - RUN: normal operation.
  - FLUSH: a down-counter `flush_cnt` is active.
- Priority 1, memory wait: mem_read_Memory=1 and mem_ready=0.
  - STALL_PC, both STALL_* moderator outputs and STALL_Execute_Memory are all 1.
  - Both DUMPs are 0.
  - The state and `flush_cnt` hold their values.
- Priority 2, redirect: next_PC_select_Execute=1.
  - DUMP_Fetch_Decode=1 and DUMP_Decode_Execute=1; all STALL outputs are 0.
  - If FLUSH_CYCLES>0: go to FLUSH with `flush_cnt`=FLUSH_CYCLES; otherwise stay in RUN.
  - A simultaneous load-use hazard is ignored, because that instruction is on the wrong path.
- FLUSH state, when neither priority 1 nor priority 2 applies:
  - DUMP_Fetch_Decode=1.
  - Decrement `flush_cnt`; go to RUN when it reaches 1 (i.e. after this cycle).
  - Load-use checking is suppressed.
- Priority 3, load-use (RUN only): all of
  - valid_Decode=1,
  - mem_read_Execute=1,
  - a used rs matches writeback_Reg_Execute.

  Response: STALL_PC=1, STALL_Fetch_Decode=1, DUMP_Decode_Execute=1. This produces exactly one bubble per hazard.
- Forwarding selects (combinational, per source operand): a Memory-stage match gives 01, else a Writeback-stage match gives 10, else 00. Memory takes precedence over Writeback.

## Timing
- Outputs are combinational from the current inputs and the registered state. Every hazard acts in the same cycle it is detected, with zero cycles of latency.
- Only the state and `flush_cnt` are registered; both update on the rising clock edge.
- While reset_n=0:
  - state is RUN and `flush_cnt`=0;
  - all STALL outputs are 0;
  - both DUMPs are 1, so the pipeline fills with bubbles;
  - forwarding selects are 00.
- On the first edge after release, the DUMPs follow the normal rules.
- Reset asserted mid-FLUSH aborts the flush immediately.
- A load-use hazard costs 1 cycle.
- A redirect costs 2+FLUSH_CYCLES dumped slots.
- A memory wait lasts as long as mem_ready=0, with no timeout.

## Configuration
- HAZARD_FORWARDING_EN defined:
  - forwarding selects behave as described in Operation;
  - only load-use hazards stall.
- HAZARD_FORWARDING_EN undefined:
  - forwarding selects are tied to 00;
  - priority 3 stalls whenever a used Decode source matches the Execute, Memory or Writeback destination, regardless of load;
  - stalls repeat each cycle until the match clears;
  - memory-wait and redirect behaviour are unchanged.

## Test plan
- Load-use (forwarding on): Execute holds a load to x5 with reg_wEn_Execute=1; Decode has valid_Decode=1 and uses rs1=x5. Require STALL_PC=1, STALL_Fetch_Decode=1, DUMP_Decode_Execute=1 for exactly one cycle. Next cycle, with the load now in Memory, require forward_A_sel=01.
- Redirect with FLUSH_CYCLES=2: pulse next_PC_select_Execute for one cycle. Require both DUMPs=1 in that cycle, then DUMP_Fetch_Decode=1 for 2 more cycles, then all outputs 0.
- Memory wait: mem_read_Memory=1, mem_ready=0 for 3 cycles, with a concurrent taken branch. Require all four STALLs=1 and no DUMP during the wait. When mem_ready=1, require the redirect dump in that cycle.
- x0 and priority: destination x0 with rs1=x0 gives forward sel 00 and no stall. Memory and Writeback both writing x7 gives forward_B_sel=01.
- Reset: assert reset_n=0 during FLUSH. Require both DUMPs=1 and all STALLs=0 while reset is held. After release with idle inputs, require all outputs 0.
- No forwarding: with HAZARD_FORWARDING_EN undefined, an ALU write to x3 in Execute and Decode reading x3 gives stall plus bubble on each of 3 consecutive cycles as the instruction advances through Execute, Memory and Writeback.
